// File: rtl/cam_clk_monitor_pkg.sv
// cam_clk_monitor_pkg: FSM states, default parameters and counter widths for the camera clock monitor
package cam_clk_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_EXP_PERIOD  = 4;
    localparam int DEF_TOL         = 1;
    localparam int DEF_LOCK_COUNT  = 4;
    localparam int DEF_TIMEOUT     = 16;

    localparam int ERR_W  = 8;
    localparam int EDGE_W = 16;

endpackage

// File: rtl/cam_clk_monitor_sync_edge.sv
// cam_clk_monitor_sync_edge: synchronizes an asynchronous clock and flags its rising edges in the clk domain
module cam_clk_monitor_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // shift the input through the synchronizer chain and keep one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/cam_clk_monitor.sv
// cam_clk_monitor: measures a slow returned clock against clk, tracks lock/loss; CAM_CLK_MONITOR_MINMAX_EN adds min/max period tracking
module cam_clk_monitor
    import cam_clk_monitor_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int EXP_PERIOD  = DEF_EXP_PERIOD,
    parameter int TOL         = DEF_TOL,
    parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clkIn,
    input  logic              clr,
    output logic              locked,
    output logic              lost,
    output logic [CNT_W-1:0]  period,
    output logic              periodValid,
    output logic [ERR_W-1:0]  errCount,
    output logic [EDGE_W-1:0] edgeCount,
    output logic [CNT_W-1:0]  minPeriod,
    output logic [CNT_W-1:0]  maxPeriod
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] LO = CNT_W'(EXP_PERIOD - TOL);
    localparam logic [CNT_W-1:0] HI = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [GW-1:0]     good_q, good_d;
    logic              have_ref_q, have_ref_d;
    logic [CNT_W-1:0]  cnt_q, period_q, m;
    logic              pvalid_q, lost_q, rise, meas, in_range, timeout, lost_set, err_inc;
    logic [ERR_W-1:0]  err_q, err_base;
    logic [EDGE_W-1:0] edge_cnt_q;

    cam_clk_monitor_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
        .clk     (clk),
        .rst     (rst),
        .async_i (clkIn),
        .edge_o  (rise)
    );

    assign m        = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign in_range = (m >= LO) && (m <= HI);
    assign meas     = rise && have_ref_q;
    assign timeout  = !rise && (cnt_q == TO) && (state_q != IDLE);
    assign err_base = clr ? '0 : err_q;

    // lock acquisition: an edge always wins over a coincident timeout
    always_comb begin
        state_d    = state_q;
        good_d     = good_q;
        have_ref_d = have_ref_q;
        lost_set   = 1'b0;
        err_inc    = 1'b0;
        if (rise) begin
            have_ref_d = 1'b1;
            case (state_q)
                IDLE: begin
                    state_d = ACQ;
                    good_d  = '0;
                end
                ACQ: if (meas) begin
                    good_d  = in_range ? good_q + 1'b1 : '0;
                    state_d = (in_range && good_q == GW'(LOCK_COUNT - 1)) ? LOCKED : ACQ;
                end
                LOCKED: if (meas && !in_range) begin
                    state_d = ACQ;
                    good_d  = '0;
                    err_inc = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end else if (timeout) begin
            state_d    = IDLE;
            have_ref_d = 1'b0;
            good_d     = '0;
            lost_set   = (state_q == LOCKED);
        end
    end

    // state, period counter and status registers; clr applies first so a coincident set/increment still lands
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            good_q     <= '0;
            have_ref_q <= 1'b0;
            cnt_q      <= '0;
            period_q   <= '0;
            pvalid_q   <= 1'b0;
            lost_q     <= 1'b0;
            err_q      <= '0;
            edge_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            good_q     <= good_d;
            have_ref_q <= have_ref_d;
            cnt_q      <= rise ? '0 : m;
            period_q   <= meas ? m : period_q;
            pvalid_q   <= meas;
            lost_q     <= lost_set | (lost_q & ~clr);
            err_q      <= (err_inc && err_base != '1) ? err_base + 1'b1 : err_base;
            edge_cnt_q <= rise ? edge_cnt_q + 1'b1 : edge_cnt_q;
        end
    end

`ifdef CAM_CLK_MONITOR_MINMAX_EN
    logic [CNT_W-1:0] min_q, max_q, min_base, max_base;

    assign min_base = clr ? '1 : min_q;
    assign max_base = clr ? '0 : max_q;

    // track extremes of reported periods, updating alongside period
    always_ff @(posedge clk) begin
        if (rst) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            min_q <= (meas && m < min_base) ? m : min_base;
            max_q <= (meas && m > max_base) ? m : max_base;
        end
    end

    assign minPeriod = min_q;
    assign maxPeriod = max_q;
`else
    assign minPeriod = '0;
    assign maxPeriod = '0;
`endif

    assign locked      = (state_q == LOCKED);
    assign lost        = lost_q;
    assign period      = period_q;
    assign periodValid = pvalid_q;
    assign errCount    = err_q;
    assign edgeCount   = edge_cnt_q;

endmodule

// File: tb/tb_cam_clk_monitor.sv
// tb_cam_clk_monitor: directed checks of period measurement, lock, loss, clr priority, reset and min/max
module tb_cam_clk_monitor;

    logic        clk = 1'b0;
    logic        rst, clkIn, clr;
    logic        locked, lost, periodValid;
    logic [7:0]  period, errCount, minPeriod, maxPeriod;
    logic [15:0] edgeCount;

    int   total = 0, bad = 0;
    int   pv_cnt = 0, first_pv_ec = -1, lock_ec = -1, lock_with_pv = -1, pv0;
    logic lk_prev = 1'b0;

    cam_clk_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .clkIn       (clkIn),
        .clr         (clr),
        .locked      (locked),
        .lost        (lost),
        .period      (period),
        .periodValid (periodValid),
        .errCount    (errCount),
        .edgeCount   (edgeCount),
        .minPeriod   (minPeriod),
        .maxPeriod   (maxPeriod)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (periodValid) begin
            pv_cnt++;
            if (first_pv_ec < 0) first_pv_ec = int'(edgeCount);
        end
        if (locked && !lk_prev && lock_ec < 0) begin
            lock_ec      = int'(edgeCount);
            lock_with_pv = int'(periodValid);
        end
        lk_prev = locked;
    endtask

    task automatic run(input int n, input bit do_clr);
        for (int i = 0; i < n; i++) begin
            clkIn = (i < ((n / 2 > 0) ? n / 2 : 1));
            clr   = do_clr && (i == 2);
            tick();
        end
        clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; clkIn = 1'b0; clr = 1'b0;
        idle(3);
        check("rst_locked", locked, 0);
        check("rst_lost", lost, 0);
        check("rst_period", period, 0);
        check("rst_pv", periodValid, 0);
        check("rst_err", errCount, 0);
        check("rst_edges", edgeCount, 0);
        rst = 1'b0;
        idle(2);

        for (int k = 0; k < 10; k++) run(4, 0);
        check("t1_edges", edgeCount, 10);
        check("t1_pvcnt", pv_cnt, 9);
        check("t1_first_pv_edge", first_pv_ec, 2);
        check("t1_period", period, 4);
        check("t1_lock_edge", lock_ec, 5);
        check("t1_lock_with_pv", lock_with_pv, 1);
        check("t1_locked", locked, 1);

        run(7, 0);
        run(4, 0);
        check("t2_period7", period, 7);
        check("t2_unlocked", locked, 0);
        check("t2_err", errCount, 1);
        for (int k = 0; k < 3; k++) run(4, 0);
        check("t2_not_yet", locked, 0);
        run(4, 0);
        check("t2_relock", locked, 1);

        idle(8);
        check("t3_still_locked", locked, 1);
        check("t3_no_lost_yet", lost, 0);
        idle(12);
        check("t3_timeout_unlock", locked, 0);
        check("t3_lost", lost, 1);
        check("t3_edges", edgeCount, 16);
        pv0 = pv_cnt;
        run(4, 0);
        check("t3_ref_no_pv", pv_cnt, pv0);
        for (int k = 0; k < 3; k++) run(4, 0);
        check("t3_not_yet", locked, 0);
        run(4, 0);
        check("t3_relock", locked, 1);
        check("t3_lost_sticky", lost, 1);
        pulse_clr();
        check("t3_clr_lost", lost, 0);
        check("t3_clr_err", errCount, 0);

        idle(20);
        check("t4_lost", lost, 1);
        pulse_clr();
        for (int k = 0; k < 4; k++) begin
            run(3, 0);
            run(6, 0);
        end
        check("t4_alt_unlocked", locked, 0);
        check("t4_alt_err", errCount, 0);
        check("t4_alt_period", period, 3);
        for (int k = 0; k < 5; k++) run(5, 0);
        check("t4_p5_locked", locked, 1);
        check("t4_p5_period", period, 5);

        run(7, 0);
        run(4, 1);
        check("t5_clr_err", errCount, 1);
        check("t5_unlocked", locked, 0);
        check("t5_period", period, 7);

        idle(20);
        check("t6_acq_timeout_no_lost", lost, 0);
        pulse_clr();
        run(4, 0); run(5, 0); run(3, 0); run(4, 0); run(4, 0);
        check("t6_period", period, 4);
`ifdef CAM_CLK_MONITOR_MINMAX_EN
        check("t6_min", minPeriod, 3);
        check("t6_max", maxPeriod, 5);
`else
        check("t6_min", minPeriod, 0);
        check("t6_max", maxPeriod, 0);
`endif
        pulse_clr();
`ifdef CAM_CLK_MONITOR_MINMAX_EN
        check("t6_min_clr", minPeriod, 8'hFF);
        check("t6_max_clr", maxPeriod, 0);
`else
        check("t6_min_clr", minPeriod, 0);
        check("t6_max_clr", maxPeriod, 0);
`endif

        clkIn = 1'b1;
        idle(2);
        rst = 1'b1; clkIn = 1'b0;
        tick();
        check("t7_locked", locked, 0);
        check("t7_lost", lost, 0);
        check("t7_period", period, 0);
        check("t7_pv", periodValid, 0);
        check("t7_err", errCount, 0);
        check("t7_edges", edgeCount, 0);
`ifdef CAM_CLK_MONITOR_MINMAX_EN
        check("t7_min", minPeriod, 8'hFF);
`else
        check("t7_min", minPeriod, 0);
`endif
        check("t7_max", maxPeriod, 0);
        rst = 1'b0;
        idle(2);
        pv0 = pv_cnt;
        run(4, 0);
        check("t7_ref_no_pv", pv_cnt, pv0);
        check("t7_edges_after", edgeCount, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
